// File: rtl/vram_arbiter.sv
// Shares the single-port frame buffer between display fetch (priority on address change) and a CPU requester.
// Display data lands 2 cycles after the fetch; CPU access takes >=4 cycles; a waiting CPU is force-granted after MAX_WAIT cycles.
module vram_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 64
) (
    input  logic              clock_25mhz,
    input  logic              reset,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic [DATA_W-1:0] o_disp_data,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_busy,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    localparam int              CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ACK
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_cap_we;
    logic [ADDR_W-1:0]   r_cap_addr;
    logic [DATA_W-1:0]   r_cap_wdata;
    logic                r_last_valid;
    logic [ADDR_W-1:0]   r_last_addr;
    logic                r_fetch_d1;
    logic [DATA_W-1:0]   r_disp_data;
    logic [DATA_W-1:0]   r_cpu_rdata;

    logic                w_fetch_needed;
    logic                w_cpu_grant;
    logic                w_disp_fetch;

    assign w_fetch_needed = i_disp_req && (!r_last_valid || (i_disp_addr != r_last_addr));
    assign w_cpu_grant    = (r_state == ST_WAIT) && (!w_fetch_needed || (r_wait_cnt == CNT_LAST));
    // A forced CPU grant skips the fetch; fetch_needed stays set so it retries next cycle.
    assign w_disp_fetch   = w_fetch_needed && !w_cpu_grant;

    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_cpu_ack    = 1'b0;
        o_cpu_busy   = 1'b1;
        o_ram_addr   = i_disp_addr;
        o_ram_we     = 1'b0;
        o_ram_wdata  = r_cap_wdata;
        case (r_state)
            ST_IDLE: begin
                o_cpu_busy = 1'b0;
                if (i_cpu_req) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_cpu_grant) begin
                    o_ram_addr   = r_cap_addr;
                    o_ram_we     = r_cap_we;
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                w_next_state = ST_ACK;
            end
            ST_ACK: begin
                o_cpu_ack    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_cap_we    <= 1'b0;
            r_cap_addr  <= '0;
            r_cap_wdata <= '0;
            r_cpu_rdata <= '0;
        end else begin
            if ((r_state == ST_IDLE) && i_cpu_req) begin
                r_cap_we    <= i_cpu_we;
                r_cap_addr  <= i_cpu_addr;
                r_cap_wdata <= i_cpu_wdata;
                r_wait_cnt  <= '0;
            end else if ((r_state == ST_WAIT) && !w_cpu_grant && (r_wait_cnt != CNT_LAST)) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if ((r_state == ST_DATA) && !r_cap_we) begin
                r_cpu_rdata <= i_ram_rdata;
            end
        end
    end

    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            r_last_valid <= 1'b0;
            r_last_addr  <= '0;
            r_fetch_d1   <= 1'b0;
            r_disp_data  <= '0;
        end else begin
            // Blanking and CPU writes to the displayed address both force a refetch.
            if (!i_disp_req) begin
                r_last_valid <= 1'b0;
            end else if (w_cpu_grant && r_cap_we && (r_cap_addr == r_last_addr)) begin
                r_last_valid <= 1'b0;
            end else if (w_disp_fetch) begin
                r_last_valid <= 1'b1;
                r_last_addr  <= i_disp_addr;
            end
            r_fetch_d1 <= w_disp_fetch;
            if (r_fetch_d1) begin
                r_disp_data <= i_ram_rdata;
            end
        end
    end

    assign o_disp_data = r_disp_data;
    assign o_cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a scoreboard per output stream and a behavioural VRAM.
module tb_vram_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    typedef struct { int due; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;
    typedef struct { int due; logic [DW-1:0] rdata; } ack_exp_t;
    typedef struct { int due; logic [DW-1:0] val; } dsp_exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;
    logic [DW-1:0] mem [0:1023];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit disp_done = 1'b0;
    logic [DW-1:0] last_rd;

    wr_exp_t  wq[$];
    ack_exp_t aq[$];
    dsp_exp_t dq[$];

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clock_25mhz (clk),
        .reset       (reset),
        .i_disp_req  (disp_req),
        .i_disp_addr (disp_addr),
        .o_disp_data (disp_data),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_ack   (cpu_ack),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_busy  (cpu_busy),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr[9:0]] <= bd_data;
        else if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
        ram_rdata <= mem[ram_addr[9:0]];
    end

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack;
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            if (cpu_ack) got = 1'b1;
            n++;
        end
        chk("ack_wait", int'(got), 1);
        tick();
    endtask

    always @(negedge clk) begin
        dsp_exp_t d;
        wr_exp_t w;
        ack_exp_t a;
        while (dq.size() > 0 && dq[0].due <= cyc) begin
            d = dq.pop_front();
            chk("disp_due", cyc, d.due);
            chk("disp_data", int'(disp_data), int'(d.val));
        end
        if (ram_we) begin
            if (wq.size() == 0) chk("ram_we_unexpected", 1, 0);
            else begin
                w = wq.pop_front();
                chk("wr_cycle", cyc, w.due);
                chk("wr_addr", int'(ram_addr), int'(w.addr));
                chk("wr_data", int'(ram_wdata), int'(w.data));
            end
        end
        if (cpu_ack) begin
            if (aq.size() == 0) chk("ack_unexpected", 1, 0);
            else begin
                a = aq.pop_front();
                if (a.due >= 0) chk("ack_cycle", cyc, a.due);
                chk("ack_rdata", int'(cpu_rdata), int'(a.rdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_ack;
        int n_we;
        int n;
        reset = 1'b1;
        disp_req = 1'b0; disp_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        last_rd = '0;

        for (int a = 0; a < 1024; a++) begin
            bd_we = 1'b1; bd_addr = AW'(a); bd_data = pat(AW'(a));
            tick();
        end
        bd_we = 1'b0;
        @(negedge clk);
        chk("rst_disp_data", int'(disp_data), 0);
        chk("rst_cpu_ack", int'(cpu_ack), 0);
        chk("rst_cpu_rdata", int'(cpu_rdata), 0);
        chk("rst_cpu_busy", int'(cpu_busy), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        tick();

        // Reset asserted while a captured write waits behind display fetches.
        reset = 1'b0;
        tick();
        disp_req = 1'b1; disp_addr = 15'h0220;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0300; cpu_wdata = 8'hEE;
        tick(); disp_addr = 15'h0221;
        tick(); disp_addr = 15'h0222;
        @(negedge clk);
        chk("wait_busy", int'(cpu_busy), 1);
        chk("wait_disp_data", int'(disp_data), 8'h7A);
        tick();
        reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
        @(negedge clk);
        chk("midrst_disp_data", int'(disp_data), 0);
        chk("midrst_cpu_ack", int'(cpu_ack), 0);
        chk("midrst_cpu_rdata", int'(cpu_rdata), 0);
        chk("midrst_cpu_busy", int'(cpu_busy), 0);
        chk("midrst_ram_we", int'(ram_we), 0);
        chk("midrst_ram_addr", int'(ram_addr), 0);
        n_ack = 0; n_we = 0;
        repeat (2) begin
            tick();
            @(negedge clk);
            n_ack += int'(cpu_ack); n_we += int'(ram_we);
        end
        tick();
        cpu_req = 1'b0; reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            n_ack += int'(cpu_ack); n_we += int'(ram_we);
            tick();
        end
        chk("postrst_acks", n_ack, 0);
        chk("postrst_writes", n_we, 0);
        chk("postrst_busy", int'(cpu_busy), 0);

        // Blanking write then read-back.
        n = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0123; cpu_wdata = 8'hA5;
        wq.push_back('{due: n + 1, addr: 15'h0123, data: 8'hA5});
        aq.push_back('{due: n + 3, rdata: 8'h00});
        wait_ack();
        n = cyc;
        cpu_we = 1'b0;
        aq.push_back('{due: n + 3, rdata: 8'hA5});
        wait_ack();
        cpu_req = 1'b0;
        last_rd = 8'hA5;
        tick();

        // Active video with a new display address every 4 cycles and back-to-back CPU reads.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    disp_req = 1'b1;
                    disp_addr = AW'(15'h0200 + i);
                    dq.push_back('{due: cyc + 2, val: pat(AW'(15'h0200 + i))});
                    dq.push_back('{due: cyc + 3, val: pat(AW'(15'h0200 + i))});
                    repeat (4) tick();
                end
                disp_req = 1'b0;
                disp_done = 1'b1;
            end
            begin
                int j;
                j = 0;
                while (!disp_done) begin
                    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(15'h0300 + j);
                    last_rd = pat(AW'(15'h0300 + j));
                    aq.push_back('{due: -1, rdata: pat(AW'(15'h0300 + j))});
                    wait_ack();
                    j++;
                end
                cpu_req = 1'b0;
            end
        join
        repeat (3) tick();

        // Display address moves every cycle; the waiting write is forced through on its 4th WAIT cycle.
        for (int k = 0; k < 10; k++) begin
            n = cyc;
            disp_req = 1'b1;
            disp_addr = AW'(15'h0210 + k);
            if (k == 1) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0310; cpu_wdata = 8'h77;
                wq.push_back('{due: n + 4, addr: 15'h0310, data: 8'h77});
                aq.push_back('{due: n + 6, rdata: last_rd});
            end
            if (k == 8) cpu_req = 1'b0;
            if (k == 5) dq.push_back('{due: n + 2, val: pat(15'h0214)});
            else        dq.push_back('{due: n + 2, val: pat(AW'(15'h0210 + k))});
            tick();
        end
        disp_req = 1'b0;
        repeat (3) tick();

        // CPU write to the address currently on screen.
        n = cyc;
        disp_req = 1'b1; disp_addr = 15'h0050;
        dq.push_back('{due: n + 2, val: 8'h0A});
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0050; cpu_wdata = 8'h3C;
        wq.push_back('{due: n + 2, addr: 15'h0050, data: 8'h3C});
        aq.push_back('{due: n + 4, rdata: last_rd});
        dq.push_back('{due: n + 4, val: 8'h0A});
        dq.push_back('{due: n + 5, val: 8'h3C});
        dq.push_back('{due: n + 6, val: 8'h3C});
        wait_ack();
        cpu_req = 1'b0;
        repeat (2) tick();

        // Line start: one blanking cycle at an unchanged address must still refetch.
        disp_req = 1'b0;
        bd_we = 1'b1; bd_addr = 15'h0050; bd_data = 8'h99;
        tick();
        bd_we = 1'b0;
        disp_req = 1'b1;
        dq.push_back('{due: cyc + 1, val: 8'h3C});
        dq.push_back('{due: cyc + 2, val: 8'h99});
        repeat (4) tick();
        disp_req = 1'b0;
        repeat (2) tick();

        chk("disp_queue_left", dq.size(), 0);
        chk("wr_queue_left", wq.size(), 0);
        chk("ack_queue_left", aq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port synchronous 160x120x8 frame buffer between the VGA display fetch path and a CPU-side requester.
- Display fetches have priority during active video and are only issued when the display address changes (once per 4 pixels). The CPU gets all remaining cycles.
- A starvation counter forces a CPU grant after MAX_WAIT cycles.
- Sits between the VGA timing block, the CPU bus bridge and the VRAM instance.

Parameters:
ADDR_W, 15, VRAM address width
DATA_W, 8, pixel/data width (RGB 3-3-2)
MAX_WAIT, 64, max cycles a captured CPU request may wait before forced grant (>=1)

Ports:
clock_25mhz  in  1  pixel clock; all state on rising edge
reset  in  1  asynchronous, active-high
disp_req  in  1  display active (inside_video)
disp_addr  in  ADDR_W  frame-buffer address of current pixel
disp_data  out  DATA_W  fetched pixel byte, registered
cpu_req  in  1  CPU request; held with addr/we/wdata stable until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid with cpu_ack, held until next read completes
cpu_busy  out  1  high in any state other than IDLE
ram_addr  out  ADDR_W  VRAM address (combinational from grant)
ram_we  out  1  VRAM write enable
ram_wdata  out  DATA_W  VRAM write data
ram_rdata  in  DATA_W  VRAM read data, valid the cycle after ram_addr is applied

Behaviour:
- Reset state:
  - FSM in IDLE.
  - disp_data=0, cpu_ack=0, cpu_rdata=0, cpu_busy=0.
  - last_valid=0, last_addr=0, wait_cnt=0.
  - ram_we=0, ram_addr=0.
- Reset mid-operation abandons any captured request. No ack is issued and no write occurs after reset asserts.
- fetch_needed = disp_req && (!last_valid || disp_addr != last_addr).
- disp_req low clears last_valid, so the first pixel of every line refetches.
- CPU FSM:
  - IDLE: if cpu_req, capture we/addr/wdata into internal registers, clear wait_cnt, go to WAIT.
  - WAIT: CPU is granted when !fetch_needed or wait_cnt==MAX_WAIT-1. On grant, go to DATA; otherwise increment wait_cnt.
  - DATA: capture ram_rdata into cpu_rdata if a read; go to ACK.
  - ACK: cpu_ack=1 for exactly this cycle; go to IDLE.
- The requester must drop cpu_req or present a new request after ack. IDLE resamples cpu_req, so the minimum is 4 cycles per CPU access.
- Grant each cycle:
  - CPU granted: ram_addr=captured addr, ram_we=captured we, ram_wdata=captured wdata.
  - Else if fetch_needed: display fetch with ram_addr=disp_addr, ram_we=0; at the edge last_addr<=disp_addr, last_valid<=1.
  - Else: ram_addr=disp_addr, ram_we=0 (idle read).
- Forced CPU grant: the display fetch is skipped that cycle. fetch_needed stays true and the fetch retries next cycle. disp_data holds its old value meanwhile; the glitch is accepted.
- Display latency: fetch issued in cycle N; disp_data updated at the edge ending N+1; valid from N+2. It holds between fetches.
- Coherency: a CPU write granted to an address equal to last_addr clears last_valid, forcing a refetch.
- Writes: RAM is written at the edge ending the grant cycle; ack comes 2 cycles after the grant.
- Simultaneous events:
  - cpu_req in the same cycle as a display fetch: capture proceeds, and the display takes the RAM.
  - disp_addr changes in the cycle a forced CPU grant occurs: the new address is fetched next cycle.
- wait_cnt saturates; it is never compared beyond MAX_WAIT-1.

Test Plan:
- Reset: assert reset mid-WAIT with cpu_req=1 -> outputs all 0, no cpu_ack, no ram_we pulse, FSM in IDLE.
- Blanking write: disp_req=0, CPU write addr 0x0123 data 0xA5 -> ram_we=1 on the cycle after capture, cpu_ack 2 cycles later; subsequent read of 0x0123 returns cpu_rdata=0xA5 with ack.
- Interleave: disp_req=1, disp_addr incrementing every 4 cycles, continuous CPU reads -> one display fetch per address change, CPU served in gaps, disp_data matches RAM contents with 2-cycle latency.
- Starvation: MAX_WAIT=4, fetch_needed forced true every cycle (disp_addr changes each cycle) -> CPU granted on the 4th WAIT cycle, display fetch retried the next cycle.
- Coherency: display holding addr 0x0050 (last_valid=1), CPU writes 0x3C to 0x0050 -> refetch issued, disp_data=0x3C.
- Line start: disp_req 0->1 at an unchanged disp_addr -> fetch issued on the first cycle because last_valid was cleared.
